// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, 32 iterations per operation, fixed 34-cycle request-to-result latency.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            MUL_en,
  input  logic            MULH_en,
  input  logic            MULHSU_en,
  input  logic            MULHU_en,
  input  logic            DIV_en,
  input  logic            DIVU_en,
  input  logic            REM_en,
  input  logic            REMU_en,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // Multiply ops occupy codes 0-3 so op[2] distinguishes multiply from divide.
  typedef enum logic [2:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU
  } op_e;

  state_e      state, state_d;
  logic [5:0]  cnt;
  op_e         req_op, op_q;
  logic        any_en;
  logic        accept;

  logic [63:0] acc;
  logic [31:0] opb;
  logic [31:0] a_raw;
  logic [4:0]  rd_q;
  logic        neg_res, neg_rem, div_zero, div_ovf;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quot, rem, final_res;

  // Fixed-priority strobe decode.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    req_op = OP_MUL;
    any_en = 1'b1;
    if      (MUL_en)    req_op = OP_MUL;
    else if (MULH_en)   req_op = OP_MULH;
    else if (MULHSU_en) req_op = OP_MULHSU;
    else if (MULHU_en)  req_op = OP_MULHU;
    else if (DIV_en)    req_op = OP_DIV;
    else if (DIVU_en)   req_op = OP_DIVU;
    else if (REM_en)    req_op = OP_REM;
    else if (REMU_en)   req_op = OP_REMU;
    else                any_en = 1'b0;
  end

  assign accept = (state == S_IDLE) && start && any_en;
  assign busy   = (state != S_IDLE);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (cnt == 6'(ITER - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Signed operands become magnitudes; the signs are folded back in at DONE.
  always_comb begin
    a_neg = rs1_val[31] && (req_op == OP_MULH || req_op == OP_MULHSU ||
                            req_op == OP_DIV  || req_op == OP_REM);
    b_neg = rs2_val[31] && (req_op == OP_MULH || req_op == OP_DIV ||
                            req_op == OP_REM);
    a_mag = a_neg ? (32'd0 - rs1_val) : rs1_val;
    b_mag = b_neg ? (32'd0 - rs2_val) : rs2_val;
  end

  // Multiply: acc = {partial high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_trial = {1'b0, acc[63:31]} - {2'b00, opb};
    div_next  = div_trial[33] ? {acc[62:0], 1'b0}
                              : {div_trial[31:0], acc[30:0], 1'b1};
  end

  always_comb begin
    prod = neg_res ? (64'd0 - acc) : acc;
    quot = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
    rem  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
    case (op_q)
      OP_MUL:                        final_res = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod[63:32];
      OP_DIV, OP_DIVU:               final_res = quot;
      default:                       final_res = rem;
    endcase
    if (div_zero) begin
      if (op_q == OP_DIV || op_q == OP_DIVU)      final_res = 32'hFFFF_FFFF;
      else if (op_q == OP_REM || op_q == OP_REMU) final_res = a_raw;
    end else if (div_ovf) begin
      final_res = (op_q == OP_DIV) ? 32'h8000_0000 : 32'd0;
    end
  end

  // Control and visible outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= 6'd0;
      result_valid <= 1'b0;
      result       <= '0;
      rd_out       <= 5'd0;
    end else begin
      state        <= state_d;
      result_valid <= (state == S_DONE);
      if (accept)
        cnt <= 6'd0;
      else if (state == S_RUN)
        cnt <= cnt + 6'd1;
      if (state == S_DONE) begin
        result <= final_res;
        rd_out <= rd_q;
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded at accept
  // before being read, and leaving them unreset keeps the reset net small.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= req_op;
      rd_q     <= rd_in;
      a_raw    <= rs1_val;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (rs2_val == 32'd0);
      div_ovf  <= (req_op == OP_DIV || req_op == OP_REM) &&
                  rs1_val == 32'h8000_0000 && rs2_val == 32'hFFFF_FFFF;
      if (!req_op[2]) begin
        acc <= {32'd0, b_mag};
        opb <= a_mag;
      end else begin
        acc <= {32'd0, a_mag};
        opb <= b_mag;
      end
    end else if (state == S_RUN) begin
      acc <= op_q[2] ? div_next : mul_next;
    end
  end

endmodule
